multicycle_controller: RTL and testbench

- Parametrised multi-cycle control FSM for the RV32I core. It replaces the single-cycle main decoder when instruction and data share one memory port that may have variable latency.
- Sequences each instruction through fetch, decode, execute, memory and writeback, driving datapath mux selects and write enables.
- Evaluates all six conditional branch types.
- Handles a memory-ready handshake.
- Traps on illegal or disabled opcodes.

---
 rtl/multicycle_controller_pkg.sv | 48 ++++
 rtl/multicycle_controller_if.sv | 21 ++
 rtl/multicycle_controller_branch_cond.sv | 23 ++
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, state and datapath-select encodings for the RV32I multi-cycle controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXER   = 4'd6;
    localparam logic [3:0] S_EXEI   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_JALR   = 4'd11;
    localparam logic [3:0] S_JLINK  = 4'd12;
    localparam logic [3:0] S_UPPER  = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_e;
    typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1, SRCA_ZERO} alu_src_a_e;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} alu_src_b_e;
    typedef enum logic [1:0] {RES_ALUOUT, RES_READDATA, RES_ALURESULT} result_src_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_e;

    function automatic imm_src_e imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:        return IMM_S;
            OP_BRANCH:       return IMM_B;
            OP_JAL:          return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:         return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory control bundle; master is the controller side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done, illegal;

    modport master (
        input  op, funct3, zero, lt, ltu, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );
    modport slave (
        output op, funct3, zero, lt, ltu, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// Conditional-branch evaluation from funct3 and ALU flags; valid=0 for the two unused encodings.
module branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o,
    output logic       valid_o
);
    always_comb begin
        taken_o = 1'b0;
        valid_o = 1'b1;
        case (funct3_i)
            3'b000:  taken_o = zero_i;
            3'b001:  taken_o = !zero_i;
            3'b100:  taken_o = lt_i;
            3'b101:  taken_o = !lt_i;
            3'b110:  taken_o = ltu_i;
            3'b111:  taken_o = !ltu_i;
            default: valid_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM sharing one variable-latency memory port.
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC on done
// DECODE | classify op, precompute OldPC+imm
// MEMADR | rs1+imm address for lw/sw
// MEMRD  | load access, wait for done
// MEMWB  | ReadData -> rd
// MEMWR  | store access, wait for done
// EXER   | R-type ALU op
// EXEI   | I-type ALU op
// ALUWB  | ALUOut -> rd
// BRANCH | compare rs1/rs2, PC <- target if taken
// JAL    | PC <- target, ALU computes OldPC+4
// JALR   | PC <- rs1+imm
// JLINK  | OldPC+4 -> rd
// UPPER  | lui/auipc result
// TRAP   | illegal opcode, sticky until reset
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit EN_UPPER        = 1'b1,
    parameter bit EN_JALR         = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master ctl
);
    logic [3:0] state_q, state_d, dec_next, bad_next;
    logic       done, taken, br_valid;

    branch_cond u_branch_cond (
        .funct3_i (ctl.funct3),
        .zero_i   (ctl.zero),
        .lt_i     (ctl.lt),
        .ltu_i    (ctl.ltu),
        .taken_o  (taken),
        .valid_o  (br_valid)
    );

    assign done     = MEM_HANDSHAKE ? ctl.mem_ready : 1'b1;
    assign bad_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    assign ctl.ImmSrc = imm_sel(ctl.op);

    always_comb begin
        case (ctl.op)
            OP_LOAD, OP_STORE: dec_next = S_MEMADR;
            OP_R:              dec_next = S_EXER;
            OP_I:              dec_next = S_EXEI;
            OP_BRANCH:         dec_next = br_valid ? S_BRANCH : bad_next;
            OP_JAL:            dec_next = S_JAL;
            OP_JALR:           dec_next = EN_JALR ? S_JALR : bad_next;
            OP_LUI, OP_AUIPC:  dec_next = EN_UPPER ? S_UPPER : bad_next;
            default:           dec_next = bad_next;
        endcase
    end

    always_comb begin
        case (state_q)
            S_FETCH:  state_d = done ? S_DECODE : S_FETCH;
            S_DECODE: state_d = dec_next;
            S_MEMADR: state_d = (ctl.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = done ? S_FETCH : S_MEMWR;
            S_EXER, S_EXEI, S_JAL, S_UPPER: state_d = S_ALUWB;
            S_JALR:   state_d = S_JLINK;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ctl.mem_req    = 1'b0;
        ctl.AdrSrc     = 1'b0;
        ctl.IRWrite    = 1'b0;
        ctl.PCWrite    = 1'b0;
        ctl.RegWrite   = 1'b0;
        ctl.MemWrite   = 1'b0;
        ctl.instr_done = 1'b0;
        ctl.illegal    = 1'b0;
        ctl.ResultSrc  = RES_ALUOUT;
        ctl.ALUSrcA    = SRCA_PC;
        ctl.ALUSrcB    = SRCB_RS2;
        ctl.ALUOp      = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req   = 1'b1;
                ctl.IRWrite   = done;
                ctl.PCWrite   = done;
                ctl.ALUSrcB   = SRCB_FOUR;
                ctl.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ctl.ALUSrcA = SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ctl.ResultSrc  = RES_READDATA;
                ctl.RegWrite   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_req    = 1'b1;
                ctl.AdrSrc     = 1'b1;
                ctl.MemWrite   = 1'b1;
                ctl.instr_done = done;
            end
            S_EXER: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUOp   = ALU_FUNCT;
            end
            S_EXEI: begin
                ctl.ALUSrcA = SRCA_RS1;
                ctl.ALUSrcB = SRCB_IMM;
                ctl.ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctl.RegWrite   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl.ALUSrcA    = SRCA_RS1;
                ctl.ALUOp      = ALU_SUB;
                ctl.PCWrite    = taken;
                ctl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctl.ALUSrcA = SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_FOUR;
                ctl.PCWrite = 1'b1;
            end
            S_JALR: begin
                ctl.ALUSrcA   = SRCA_RS1;
                ctl.ALUSrcB   = SRCB_IMM;
                ctl.ResultSrc = RES_ALURESULT;
                ctl.PCWrite   = 1'b1;
            end
            S_JLINK: begin
                ctl.ALUSrcA    = SRCA_OLDPC;
                ctl.ALUSrcB    = SRCB_FOUR;
                ctl.ResultSrc  = RES_ALURESULT;
                ctl.RegWrite   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_UPPER: begin
                ctl.ALUSrcA = (ctl.op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                ctl.ALUSrcB = SRCB_IMM;
            end
            S_TRAP:  ctl.illegal = 1'b1;
            default: ;
        endcase
        // Reset kills every strobe combinationally so nothing leaks before the flop clears.
        if (!reset) begin
            ctl.mem_req    = 1'b0;
            ctl.IRWrite    = 1'b0;
            ctl.PCWrite    = 1'b0;
            ctl.RegWrite   = 1'b0;
            ctl.MemWrite   = 1'b0;
            ctl.instr_done = 1'b0;
            ctl.illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench for multicycle_controller (default build and EN_JALR=0 build).
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = OP_R;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
    int         errors = 0;
    int         checks = 0;

    logic [15:0] exp_q[$];
    bit          mr_q[$];
    string       tag_q[$];

    multicycle_controller_if bus0();
    multicycle_controller_if bus1();

    assign bus0.op = op;         assign bus1.op = op;
    assign bus0.funct3 = funct3; assign bus1.funct3 = funct3;
    assign bus0.zero = zero;     assign bus1.zero = zero;
    assign bus0.lt = lt;         assign bus1.lt = lt;
    assign bus0.ltu = ltu;       assign bus1.ltu = ltu;
    assign bus0.mem_ready = mem_ready;
    assign bus1.mem_ready = mem_ready;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .EN_UPPER(1'b1), .EN_JALR(1'b1),
                            .TRAP_ON_ILLEGAL(1'b1))
        dut (.clk(clk), .reset(reset), .ctl(bus0.master));
    multicycle_controller #(.MEM_HANDSHAKE(1'b1), .EN_UPPER(1'b1), .EN_JALR(1'b0),
                            .TRAP_ON_ILLEGAL(1'b1))
        dut_nj (.clk(clk), .reset(reset), .ctl(bus1.master));

    always #5 clk = ~clk;

    // {mem_req,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,instr_done,illegal,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    function automatic logic [15:0] ev(input logic mq, ad, ir, pc, rw, mw, dn, il,
                                       input logic [1:0] rs, a, b, ao);
        return {mq, ad, ir, pc, rw, mw, dn, il, rs, a, b, ao};
    endfunction

    function automatic logic [15:0] observe(input bit sel);
        if (sel)
            return {bus1.mem_req, bus1.AdrSrc, bus1.IRWrite, bus1.PCWrite, bus1.RegWrite,
                    bus1.MemWrite, bus1.instr_done, bus1.illegal, bus1.ResultSrc,
                    bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp};
        return {bus0.mem_req, bus0.AdrSrc, bus0.IRWrite, bus0.PCWrite, bus0.RegWrite,
                bus0.MemWrite, bus0.instr_done, bus0.illegal, bus0.ResultSrc,
                bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp};
    endfunction

    function automatic logic [15:0] e_rst();   return ev(0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00); endfunction
    function automatic logic [15:0] e_fetch(input logic d); return ev(1,0,d,d,0,0,0,0, 2'b10,2'b00,2'b10,2'b00); endfunction
    function automatic logic [15:0] e_decode(); return ev(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00); endfunction
    function automatic logic [15:0] e_memadr(); return ev(0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00); endfunction
    function automatic logic [15:0] e_memrd();  return ev(1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00); endfunction
    function automatic logic [15:0] e_memwb();  return ev(0,0,0,0,1,0,1,0, 2'b01,2'b00,2'b00,2'b00); endfunction
    function automatic logic [15:0] e_memwr(input logic d); return ev(1,1,0,0,0,1,d,0, 2'b00,2'b00,2'b00,2'b00); endfunction
    function automatic logic [15:0] e_exer();   return ev(0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10); endfunction
    function automatic logic [15:0] e_exei();   return ev(0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10); endfunction
    function automatic logic [15:0] e_aluwb();  return ev(0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00); endfunction
    function automatic logic [15:0] e_branch(input logic t); return ev(0,0,0,t,0,0,1,0, 2'b00,2'b10,2'b00,2'b01); endfunction
    function automatic logic [15:0] e_jal();    return ev(0,0,0,1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00); endfunction
    function automatic logic [15:0] e_jalr();   return ev(0,0,0,1,0,0,0,0, 2'b10,2'b10,2'b01,2'b00); endfunction
    function automatic logic [15:0] e_jlink();  return ev(0,0,0,0,1,0,1,0, 2'b10,2'b01,2'b10,2'b00); endfunction
    function automatic logic [15:0] e_upper(input logic [1:0] a); return ev(0,0,0,0,0,0,0,0, 2'b00,a,2'b01,2'b00); endfunction
    function automatic logic [15:0] e_trap();   return ev(0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00); endfunction

    task automatic push(input string t, input bit mr, input logic [15:0] e);
        tag_q.push_back(t);
        mr_q.push_back(mr);
        exp_q.push_back(e);
    endtask

    // One queue entry per clock: drive mem_ready at negedge, compare 1 ns later.
    task automatic run_queue(input bit sel);
        while (exp_q.size() > 0) begin
            logic [15:0] e, o;
            string t;
            @(negedge clk);
            mem_ready = mr_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            #1;
            o = observe(sel);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s (dut%0d): got %h expected %h", t, sel, o, e);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (observe(s[0]) !== e_rst()) begin
                errors++;
                $display("FAIL pulse_reset (dut%0d): got %h expected %h", s, observe(s[0]), e_rst());
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) push("reset_hold", 1'b1, e_rst());
        run_queue(1'b0);
        checks++;
        if (observe(1'b1) !== e_rst()) begin
            errors++;
            $display("FAIL reset_hold (dut1): got %h expected %h", observe(1'b1), e_rst());
        end
        mem_ready = 1'b0;
        reset = 1'b1;
        push("reset_first_fetch", 1'b0, e_fetch(1'b0));
        run_queue(1'b0);
    endtask

    task automatic test_alu();
        op = OP_R;
        push("add_fetch", 1, e_fetch(1)); push("add_decode", 1, e_decode());
        push("add_exer", 1, e_exer());    push("add_aluwb", 1, e_aluwb());
        run_queue(1'b0);
        op = OP_I;
        push("addi_fetch", 1, e_fetch(1)); push("addi_decode", 1, e_decode());
        push("addi_exei", 1, e_exei());    push("addi_aluwb", 1, e_aluwb());
        run_queue(1'b0);
    endtask

    task automatic test_lw_wait();
        op = OP_LOAD; funct3 = 3'b010;
        push("lw_fetch_wait", 0, e_fetch(0)); push("lw_fetch", 1, e_fetch(1));
        push("lw_decode", 1, e_decode());     push("lw_memadr", 1, e_memadr());
        push("lw_memrd_w0", 0, e_memrd());    push("lw_memrd_w1", 0, e_memrd());
        push("lw_memrd", 1, e_memrd());       push("lw_memwb", 1, e_memwb());
        run_queue(1'b0);
    endtask

    task automatic test_branch();
        logic [2:0] f3 [4] = '{3'b101, 3'b101, 3'b000, 3'b110};
        logic       ltv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       zv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        op = OP_BRANCH; ltu = 1'b0;
        for (int i = 0; i < 4; i++) begin
            funct3 = f3[i]; lt = ltv[i]; zero = zv[i];
            push("br_fetch", 1, e_fetch(1)); push("br_decode", 1, e_decode());
            push($sformatf("br_%0d_f3_%b", i, f3[i]), 1, e_branch(tk[i]));
            run_queue(1'b0);
        end
        funct3 = 3'b010;
        push("br_bad_fetch", 1, e_fetch(1)); push("br_bad_decode", 1, e_decode());
        push("br_bad_trap", 1, e_trap());    push("br_bad_trap_sticky", 1, e_trap());
        run_queue(1'b0);
        pulse_reset();
    endtask

    task automatic test_jal_upper();
        logic [6:0] ops[3] = '{OP_JAL, OP_LUI, OP_AUIPC};
        for (int i = 0; i < 3; i++) begin
            op = ops[i];
            push("ju_fetch", 1, e_fetch(1)); push("ju_decode", 1, e_decode());
            if (i == 0)      push("jal_jal", 1, e_jal());
            else if (i == 1) push("lui_upper", 1, e_upper(2'b11));
            else             push("auipc_upper", 1, e_upper(2'b01));
            push("ju_aluwb", 1, e_aluwb());
            run_queue(1'b0);
        end
    endtask

    task automatic test_jalr();
        op = OP_JALR; funct3 = 3'b000;
        push("jalr_fetch", 1, e_fetch(1)); push("jalr_decode", 1, e_decode());
        push("jalr_jalr", 1, e_jalr());    push("jalr_jlink", 1, e_jlink());
        run_queue(1'b0);
        pulse_reset();
        push("nojalr_fetch", 1, e_fetch(1)); push("nojalr_decode", 1, e_decode());
        push("nojalr_trap", 1, e_trap());    push("nojalr_trap_sticky", 1, e_trap());
        run_queue(1'b1);
        pulse_reset();
    endtask

    task automatic test_back_to_back_sw_reset();
        op = OP_STORE; funct3 = 3'b010;
        push("sw_fetch", 1, e_fetch(1));  push("sw_decode", 1, e_decode());
        push("sw_memadr", 1, e_memadr()); push("sw_memwr", 1, e_memwr(1));
        push("sw2_fetch", 1, e_fetch(1)); push("sw2_decode", 1, e_decode());
        push("sw2_memadr", 1, e_memadr()); push("sw2_memwr_wait", 0, e_memwr(0));
        run_queue(1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (observe(1'b0) !== e_rst()) begin
            errors++;
            $display("FAIL sw_abort_reset: got %h expected %h", observe(1'b0), e_rst());
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        push("restart_fetch_wait", 0, e_fetch(0)); push("restart_fetch", 1, e_fetch(1));
        push("restart_decode", 1, e_decode());     push("restart_memadr", 1, e_memadr());
        push("restart_memwr", 1, e_memwr(1));
        run_queue(1'b0);
    endtask

    task automatic test_immsrc();
        logic [6:0] ops[9] = '{OP_LOAD, OP_I, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL,
                               OP_LUI, OP_AUIPC, OP_R};
        logic [2:0] imm[9] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011,
                               3'b100, 3'b100, 3'b000};
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            op = ops[i];
            #1;
            checks++;
            if (bus0.ImmSrc !== imm[i]) begin
                errors++;
                $display("FAIL immsrc op=%b: got %b expected %b", ops[i], bus0.ImmSrc, imm[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_jal_upper();
        test_jalr();
        test_back_to_back_sw_reset();
        test_immsrc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
